exp_unpacker: RTL and testbench

Fetch-side stage directly upstream of the dispatcher BRAM's aligned-exponent buffers. On a start pulse it walks the 16 packed-exponent staging lines of one side (left or right) over the BRAM's combinational packed read port. It splits each 256-bit line into 32 8-bit exponents and writes them, one per cycle, into that side's 512-entry aligned-exponent buffer. It runs while the fetcher streams mantissa lines, and reports busy/done to the fetch controller.

---
 rtl/dispatcher_pkg.sv | 22 ++
 rtl/exp_byte_select.sv | 20 ++
 rtl/exp_unpacker.sv | 151 +++++++++++++++
 tb/tb_exp_unpacker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared geometry, FSM state and side encodings for the dispatcher fetch-side blocks.
package dispatcher_pkg;

    localparam int MAN_WIDTH        = 256;
    localparam int EXP_WIDTH        = 8;
    localparam int EXP_PACKED_DEPTH = 16;
    localparam int BRAM_DEPTH       = 512;
    localparam int EXP_PER_LINE     = MAN_WIDTH / EXP_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNPACK = 2'd2,
        DONE   = 2'd3
    } unpack_state_t;

    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_t;

endpackage

// File: rtl/exp_byte_select.sv
// Selects one EXP_WIDTH exponent out of a packed staging line.
module exp_byte_select #(
    parameter int EXP_WIDTH    = dispatcher_pkg::EXP_WIDTH,
    parameter int EXP_PER_LINE = dispatcher_pkg::EXP_PER_LINE,
    parameter int SEL_WIDTH    = $clog2(EXP_PER_LINE)
) (
    input  logic [EXP_WIDTH*EXP_PER_LINE-1:0] line,
    input  logic [SEL_WIDTH-1:0]              sel,
    output logic [EXP_WIDTH-1:0]              exp_out
);

    logic [EXP_WIDTH-1:0] slices [EXP_PER_LINE];

    for (genvar i = 0; i < EXP_PER_LINE; i++) begin : g_slice
        assign slices[i] = line[i*EXP_WIDTH +: EXP_WIDTH];
    end

    assign exp_out = slices[sel];

endmodule

// File: rtl/exp_unpacker.sv
// Walks the packed exponent staging lines of one side and writes each exponent into
// that side's aligned buffer. Define EXP_UNPACK_LINE_REG_EN to register each line first.
//
// state  | meaning
// IDLE   | waiting for i_start; target and counters loaded on acceptance
// LOAD   | (line-register build only) capture packed line line_cnt, no write
// UNPACK | one aligned write per cycle at {line_cnt, byte_cnt}
// DONE   | one-cycle o_done pulse, then back to IDLE
module exp_unpacker #(
    parameter int MAN_WIDTH             = dispatcher_pkg::MAN_WIDTH,
    parameter int EXP_WIDTH             = dispatcher_pkg::EXP_WIDTH,
    parameter int EXP_PACKED_DEPTH      = dispatcher_pkg::EXP_PACKED_DEPTH,
    parameter int BRAM_DEPTH            = dispatcher_pkg::BRAM_DEPTH,
    parameter int RD_ADDR_WIDTH         = $clog2(BRAM_DEPTH),
    parameter int EXP_PACKED_ADDR_WIDTH = $clog2(EXP_PACKED_DEPTH)
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic                             i_target,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [EXP_PACKED_ADDR_WIDTH-1:0] o_exp_packed_rd_addr,
    output logic                             o_exp_packed_rd_target,
    input  logic [MAN_WIDTH-1:0]             i_exp_packed_rd_data,
    output logic [RD_ADDR_WIDTH-1:0]         o_exp_left_wr_addr,
    output logic                             o_exp_left_wr_en,
    output logic [EXP_WIDTH-1:0]             o_exp_left_wr_data,
    output logic [RD_ADDR_WIDTH-1:0]         o_exp_right_wr_addr,
    output logic                             o_exp_right_wr_en,
    output logic [EXP_WIDTH-1:0]             o_exp_right_wr_data
);

    import dispatcher_pkg::*;

    localparam int N_EXP  = MAN_WIDTH / EXP_WIDTH;
    localparam int BYTE_W = $clog2(N_EXP);

    if (N_EXP * EXP_PACKED_DEPTH != BRAM_DEPTH) begin : g_bad_geometry
        $error("exp_unpacker: lines x exponents-per-line must equal BRAM_DEPTH");
    end

`ifdef EXP_UNPACK_LINE_REG_EN
    localparam unpack_state_t LINE_ENTRY = LOAD;
`else
    localparam unpack_state_t LINE_ENTRY = UNPACK;
`endif

    unpack_state_t                    state, state_next;
    logic [EXP_PACKED_ADDR_WIDTH-1:0] line_cnt;
    logic [BYTE_W-1:0]                byte_cnt;
    side_t                            target;
    logic                             byte_last, line_last;
    logic                             wr_en, left_en, right_en;
    logic [RD_ADDR_WIDTH-1:0]         wr_addr;
    logic [EXP_WIDTH-1:0]             wr_data;
    logic [MAN_WIDTH-1:0]             line_src;

    assign byte_last = (byte_cnt == BYTE_W'(N_EXP - 1));
    assign line_last = (line_cnt == EXP_PACKED_ADDR_WIDTH'(EXP_PACKED_DEPTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            line_cnt <= '0;
            byte_cnt <= '0;
            target   <= SIDE_LEFT;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        target   <= side_t'(i_target);
                        line_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                UNPACK: begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_last) line_cnt <= line_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef EXP_UNPACK_LINE_REG_EN
    // Registering the line cuts the BRAM read path out of the write-data timing.
    logic [MAN_WIDTH-1:0] line_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset)            line_reg <= '0;
        else if (state == LOAD) line_reg <= i_exp_packed_rd_data;
    end

    assign line_src = line_reg;
`else
    assign line_src = i_exp_packed_rd_data;
`endif

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_next = LINE_ENTRY;
            end
            LOAD: begin
                o_busy     = 1'b1;
                state_next = UNPACK;
            end
            UNPACK: begin
                o_busy = 1'b1;
                wr_en  = 1'b1;
                if (byte_last) state_next = line_last ? DONE : LINE_ENTRY;
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    exp_byte_select #(
        .EXP_WIDTH    (EXP_WIDTH),
        .EXP_PER_LINE (N_EXP),
        .SEL_WIDTH    (BYTE_W)
    ) u_byte_select (
        .line    (line_src),
        .sel     (byte_cnt),
        .exp_out (wr_data)
    );

    assign wr_addr  = {line_cnt, byte_cnt};
    assign left_en  = wr_en && (target == SIDE_LEFT);
    assign right_en = wr_en && (target == SIDE_RIGHT);

    assign o_exp_packed_rd_addr   = line_cnt;
    assign o_exp_packed_rd_target = target;

    assign o_exp_left_wr_en    = left_en;
    assign o_exp_left_wr_addr  = left_en ? wr_addr : '0;
    assign o_exp_left_wr_data  = left_en ? wr_data : '0;
    assign o_exp_right_wr_en   = right_en;
    assign o_exp_right_wr_addr = right_en ? wr_addr : '0;
    assign o_exp_right_wr_data = right_en ? wr_data : '0;

endmodule

// File: tb/tb_exp_unpacker.sv
// Scoreboard bench for exp_unpacker; follows EXP_UNPACK_LINE_REG_EN for latency expectations.
module tb_exp_unpacker;

`ifdef EXP_UNPACK_LINE_REG_EN
    localparam int LAT      = 528;
    localparam int FIRST_WR = 2;
`else
    localparam int LAT      = 512;
    localparam int FIRST_WR = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         target;
    logic         busy, done;
    logic [3:0]   rd_addr;
    logic         rd_target;
    logic [255:0] rd_data;
    logic [8:0]   l_addr, r_addr;
    logic         l_en, r_en;
    logic [7:0]   l_data, r_data;

    always #5 clk = ~clk;

    exp_unpacker dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_start                (start),
        .i_target               (target),
        .o_busy                 (busy),
        .o_done                 (done),
        .o_exp_packed_rd_addr   (rd_addr),
        .o_exp_packed_rd_target (rd_target),
        .i_exp_packed_rd_data   (rd_data),
        .o_exp_left_wr_addr     (l_addr),
        .o_exp_left_wr_en       (l_en),
        .o_exp_left_wr_data     (l_data),
        .o_exp_right_wr_addr    (r_addr),
        .o_exp_right_wr_en      (r_en),
        .o_exp_right_wr_data    (r_data)
    );

    logic [255:0] left_mem  [16];
    logic [255:0] right_mem [16];

    assign rd_data = rd_target ? right_mem[rd_addr] : left_mem[rd_addr];

    typedef struct packed {
        logic       side;
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int wr_cnt, busy_cnt, done_cnt, first_wr, last_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t        e;
        logic       side_o;
        logic [8:0] addr_o;
        logic [7:0] data_o;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (l_en || r_en) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            chk("one_side_wr", 32'(l_en) + 32'(r_en), 1);
            chk("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e      = exp_q.pop_front();
                side_o = r_en;
                addr_o = r_en ? r_addr : l_addr;
                data_o = r_en ? r_data : l_data;
                chk("wr_side", 32'(side_o), 32'(e.side));
                chk("wr_addr", 32'(addr_o), 32'(e.addr));
                chk("wr_data", 32'(data_o), 32'(e.data));
                chk("rd_addr", 32'(rd_addr), 32'(e.addr[8:5]));
                chk("rd_target", 32'(rd_target), 32'(e.side));
            end
        end
    end

    function automatic int writes_within(input int n);
`ifdef EXP_UNPACK_LINE_REG_EN
        int rem = n % 33;
        return (n / 33) * 32 + ((rem > 0) ? rem - 1 : 0);
`else
        return n;
`endif
    endfunction

    task automatic push_expected(input logic side, input int count);
        wr_t e;
        for (int k = 0; k < count; k++) begin
            e.side = side;
            e.addr = 9'(k);
            e.data = side ? right_mem[k / 32][(k % 32) * 8 +: 8]
                          : left_mem[k / 32][(k % 32) * 8 +: 8];
            exp_q.push_back(e);
        end
    endtask

    // Caller sits on a negedge; start is high for exactly the cycle returned in t.
    task automatic pulse_start(input logic side, input bit clr, output int t);
        start  = 1'b1;
        target = side;
        t      = cyc;
        if (clr) begin
            wr_cnt = 0; busy_cnt = 0; done_cnt = 0; first_wr = -1; last_wr = -1;
        end
        @(negedge clk);
        start  = 1'b0;
        target = ~side;
    endtask

    task automatic wait_done(output int dcyc);
        int n = 0;
        while (!done && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 1);
        dcyc = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_op(input string tag, input int t, input int dcyc);
        @(negedge clk);
        chk({tag, "_done_lat"}, dcyc - t, LAT + 1);
        chk({tag, "_first_wr"}, first_wr - t, FIRST_WR);
        chk({tag, "_last_wr"}, last_wr - t, LAT);
        chk({tag, "_wr_cnt"}, wr_cnt, 512);
        chk({tag, "_busy_cnt"}, busy_cnt, LAT);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int t, t2, d;
        rst = 1'b1; start = 1'b0; target = 1'b0;
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; first_wr = -1; last_wr = -1;
        for (int l = 0; l < 16; l++)
            for (int b = 0; b < 32; b++) begin
                left_mem[l][b*8 +: 8]  = 8'((l * 32 + b) & 8'hFF);
                right_mem[l][b*8 +: 8] = 8'($urandom_range(255));
            end

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_en", {30'b0, l_en, r_en}, 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_rd_target", 32'(rd_target), 0);
        chk("rst_wr_bus", {l_addr, r_addr, l_data[6:0]}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // Left unpack, address k carries k & 0xFF
        push_expected(1'b0, 512);
        @(negedge clk);
        pulse_start(1'b0, 1'b1, t);
        wait_done(d);
        check_op("left", t, d);

        // Right unpack, only line 3 non-zero
        for (int l = 0; l < 16; l++) right_mem[l] = (l == 3) ? {32{8'hA5}} : '0;
        push_expected(1'b1, 512);
        @(negedge clk);
        pulse_start(1'b1, 1'b1, t);
        wait_done(d);
        check_op("right", t, d);
        chk("right_target_held", 32'(rd_target), 1);

        // Start while busy with flipped side is ignored
        for (int l = 0; l < 16; l++) right_mem[l] = {8{32'($urandom)}};
        push_expected(1'b0, 512);
        @(negedge clk);
        pulse_start(1'b0, 1'b1, t);
        wait_until(t + 100);
        start = 1'b1; target = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d);
        check_op("busy_start", t, d);
        chk("busy_start_target", 32'(rd_target), 0);

        // Reset mid-operation, then restart
        push_expected(1'b1, writes_within(200));
        @(negedge clk);
        pulse_start(1'b1, 1'b1, t);
        wait_until(t + 200);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wr_en", {30'b0, l_en, r_en}, 0);
        chk("midrst_done", 32'(done), 0);
        rst = 1'b0;
        wait_until(t + 204);
        chk("midrst_wr_cnt", wr_cnt, writes_within(200));
        chk("midrst_busy_cnt", busy_cnt, 200);
        chk("midrst_done_cnt", done_cnt, 0);
        chk("midrst_q_empty", exp_q.size(), 0);
        push_expected(1'b0, 512);
        wait_until(t + 205);
        pulse_start(1'b0, 1'b1, t2);
        chk("restart_cycle", t2 - t, 205);
        wait_done(d);
        check_op("restart", t2, d);

        // Back-to-back: right start on the cycle after done is accepted
        push_expected(1'b0, 512);
        push_expected(1'b1, 512);
        @(negedge clk);
        pulse_start(1'b0, 1'b1, t);
        wait_done(d);
        chk("b2b_first_done", d - t, LAT + 1);
        @(negedge clk);
        pulse_start(1'b1, 1'b0, t2);
        chk("b2b_gap", t2 - d, 1);
        wait_done(d);
        @(negedge clk);
        chk("b2b_second_done", d - t2, LAT + 1);
        chk("b2b_wr_cnt", wr_cnt, 1024);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_last_wr", last_wr - t2, LAT);
        chk("b2b_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
